joy_port_conditioner: RTL and testbench

//  Conditions the two raw DB9 joystick ports (active-low pins) into clean, active-high
//  {fire,left,right,down,up} vectors for mainboard joy1/joy2. Sits between the FPGA pins
//  and the mainboard. Per-line 2-FF synchroniser and time-based debounce, then

---
 rtl/joy_pkg.sv | 33 +++
 rtl/joy_debounce_bit.sv | 41 ++++
 rtl/joy_port_conditioner.sv | 113 +++++++++++
 tb/tb_joy_port_conditioner.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared widths, pin indices and helpers for the DB9 joystick conditioner.
package joy_pkg;

  localparam int JOY_W     = 5;
  localparam int JOY_FIRE  = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_RIGHT = 2;
  localparam int JOY_DOWN  = 3;
  localparam int JOY_UP    = 4;

  typedef logic [0:JOY_W-1] joy_t;

  // System clocks per microsecond, never below one so the prescaler stays legal.
  function automatic int us_div(input int clk_hz);
    return (clk_hz / 1000000 < 1) ? 1 : clk_hz / 1000000;
  endfunction

  // A held opposing pair cancels out; fire is independent.
  function automatic joy_t joy_suppress(input joy_t j);
    joy_t r;
    r = j;
    if (j[JOY_UP] && j[JOY_DOWN]) begin
      r[JOY_UP]   = 1'b0;
      r[JOY_DOWN] = 1'b0;
    end
    if (j[JOY_LEFT] && j[JOY_RIGHT]) begin
      r[JOY_LEFT]  = 1'b0;
      r[JOY_RIGHT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/joy_debounce_bit.sv
// One joystick line: 2-FF synchroniser, inversion to active-high, us-based debounce.
module joy_debounce_bit #(
  parameter int DEBOUNCE_US = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic pin_n,
  output logic state
);

  localparam int CW = $clog2(DEBOUNCE_US + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          s;

  assign s = ~sync[1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync  <= 2'b11;
      cnt   <= '0;
      state <= 1'b0;
    end else begin
      sync <= {sync[0], pin_n};
      // Any return to the accepted level throws away partial progress.
      if (s == state) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CW'(DEBOUNCE_US - 1)) begin
          state <= s;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/joy_port_conditioner.sv
// Two DB9 ports -> debounced, opposite-suppressed active-high joy1/joy2 with change strobe.
// Optional autofire on the fire line when JOY_PORT_CONDITIONER_AUTOFIRE_EN is defined.
module joy_port_conditioner
  import joy_pkg::*;
#(
  parameter int CLK_HZ      = 108000000,
  parameter int DEBOUNCE_US = 5,
  parameter int AUTOFIRE_HZ = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [0:JOY_W-1] joy_a_n,
  input  logic [0:JOY_W-1] joy_b_n,
  input  logic             autofire,
  output logic [0:JOY_W-1] joy1,
  output logic [0:JOY_W-1] joy2,
  output logic             changed
);

  localparam int DIV = us_div(CLK_HZ);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_n)  pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end

  logic [2*JOY_W-1:0] pin_flat, st_flat;
  joy_t               st_a, st_b, nxt_a, nxt_b;

  assign pin_flat = {joy_a_n, joy_b_n};

  joy_debounce_bit #(.DEBOUNCE_US(DEBOUNCE_US)) u_db [2*JOY_W-1:0] (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick),
    .pin_n  (pin_flat),
    .state  (st_flat)
  );

  assign {st_a, st_b} = st_flat;

`ifdef JOY_PORT_CONDITIONER_AUTOFIRE_EN
  localparam int HALF_US = (1000000 / (2 * AUTOFIRE_HZ) < 1) ? 1 : 1000000 / (2 * AUTOFIRE_HZ);
  localparam int AW      = (HALF_US > 1) ? $clog2(HALF_US) : 1;

  logic [AW-1:0] af_cnt;
  logic          af_phase;
  logic [1:0]    fire_q;
  logic          fire_rise, af_restart, af_gate;

  assign fire_rise  = (st_a[JOY_FIRE] & ~fire_q[0]) | (st_b[JOY_FIRE] & ~fire_q[1]);
  // A fresh press on either port restarts the shared phase in its 'on' half.
  assign af_restart = ~autofire | ~(st_a[JOY_FIRE] | st_b[JOY_FIRE]) | fire_rise;
  assign af_gate    = ~autofire | af_restart | af_phase;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
      fire_q   <= 2'b00;
    end else begin
      fire_q <= {st_b[JOY_FIRE], st_a[JOY_FIRE]};
      if (af_restart) begin
        af_cnt   <= '0;
        af_phase <= 1'b1;
      end else if (tick) begin
        if (af_cnt == AW'(HALF_US - 1)) begin
          af_cnt   <= '0;
          af_phase <= ~af_phase;
        end else begin
          af_cnt <= af_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    nxt_a           = joy_suppress(st_a);
    nxt_b           = joy_suppress(st_b);
    nxt_a[JOY_FIRE] = st_a[JOY_FIRE] & af_gate;
    nxt_b[JOY_FIRE] = st_b[JOY_FIRE] & af_gate;
  end
`else
  localparam int unused_af_hz = AUTOFIRE_HZ;
  logic unused_autofire;
  assign unused_autofire = autofire;

  always_comb begin
    nxt_a = joy_suppress(st_a);
    nxt_b = joy_suppress(st_b);
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      joy1    <= '0;
      joy2    <= '0;
      changed <= 1'b0;
    end else begin
      joy1    <= nxt_a;
      joy2    <= nxt_b;
      changed <= (nxt_a != joy1) || (nxt_b != joy2);
    end
  end

endmodule

// File: tb/tb_joy_port_conditioner.sv
// Randomised and directed checks of joy_port_conditioner against a timing-level reference model.
module tb_joy_port_conditioner;

  localparam int CLK_HZ   = 10000000;
  localparam int DB_US    = 5;
  localparam int CYC_US   = 10;
  localparam int AF_HZ    = 50000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [0:4] joy_a_n, joy_b_n;
  logic       autofire;
  logic [0:4] joy1, joy2;
  logic       changed;

  always #5 clk = ~clk;

  joy_port_conditioner #(.CLK_HZ(CLK_HZ), .DEBOUNCE_US(DB_US), .AUTOFIRE_HZ(AF_HZ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .joy_a_n (joy_a_n),
    .joy_b_n (joy_b_n),
    .autofire(autofire),
    .joy1    (joy1),
    .joy2    (joy2),
    .changed (changed)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a line's accepted level follows the (2-edge delayed, inverted) pin once the
  // disagreement has spanned DB_US microsecond ticks; ticks fall on every 10th edge after reset.
  logic [0:4] m_st [2];
  int         d_start [2][5];
  int         e_cnt;
  logic [0:4] qa[$], qb[$];
  logic [0:4] m_a = '0, m_b = '0;
  logic       m_chg = 1'b0;

  function automatic logic [0:4] supp(input logic [0:4] j);
    logic [0:4] r;
    r = j;
    if (j[3] && j[4]) begin r[3] = 1'b0; r[4] = 1'b0; end
    if (j[1] && j[2]) begin r[1] = 1'b0; r[2] = 1'b0; end
    return r;
  endfunction

  task automatic model_edge(input logic [0:4] a_n, input logic [0:4] b_n, input logic rn);
    logic [0:4] s [2];
    logic [0:4] na, nb;
    if (!rn) begin
      m_st[0] = '0; m_st[1] = '0;
      for (int p = 0; p < 2; p++) for (int i = 0; i < 5; i++) d_start[p][i] = -1;
      e_cnt = 0;
      qa = {5'h1f, 5'h1f};
      qb = {5'h1f, 5'h1f};
      m_a = '0; m_b = '0; m_chg = 1'b0;
      return;
    end
    e_cnt++;
    s[0] = ~qa.pop_front();
    s[1] = ~qb.pop_front();
    qa.push_back(a_n);
    qb.push_back(b_n);
    na = supp(m_st[0]);
    nb = supp(m_st[1]);
    m_chg = (na != m_a) || (nb != m_b);
    m_a = na;
    m_b = nb;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 5; i++) begin
        if (s[p][i] == m_st[p][i]) begin
          d_start[p][i] = -1;
        end else begin
          if (d_start[p][i] < 0) d_start[p][i] = e_cnt;
          if ((e_cnt % CYC_US == 0) &&
              (e_cnt / CYC_US - (d_start[p][i] - 1) / CYC_US == DB_US)) begin
            m_st[p][i]    = s[p][i];
            d_start[p][i] = -1;
          end
        end
      end
    end
  endtask

  logic [0:4] cur_a = 5'h1f, cur_b = 5'h1f;
  logic       cur_rn = 1'b0, cur_af = 1'b0;
  bit         do_chk = 1'b1;

  task automatic step();
    joy_a_n  = cur_a;
    joy_b_n  = cur_b;
    reset_n  = cur_rn;
    autofire = cur_af;
    @(posedge clk);
    model_edge(cur_a, cur_b, cur_rn);
    #1;
    if (do_chk) chk("cycle", {21'd0, joy1, joy2, changed}, {21'd0, m_a, m_b, m_chg});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Steps until the chosen output bit is 1; passes if that happens in [lo,hi] edges.
  task automatic wait_bit(input string tag, input int port, input int idx,
                          input int lo, input int hi, output int n_chg);
    int  k;
    bit  found;
    found = 1'b0;
    n_chg = 0;
    for (k = 1; k <= hi + 10; k++) begin
      step();
      if (changed) n_chg++;
      if ((port == 0) ? joy1[idx] : joy2[idx]) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, found && k >= lo && k <= hi}, 32'd1);
  endtask

  int nc;
  int runs[$];

  initial begin
    joy_a_n = 5'h1f; joy_b_n = 5'h1f; reset_n = 1'b0; autofire = 1'b0;

    // All pins pressed through reset: outputs stay 0 until debounce completes.
    cur_a = 5'h00; cur_b = 5'h00; cur_rn = 1'b0;
    run(5);
    chk("rst_out", {21'd0, joy1, joy2, changed}, 32'd0);
    cur_rn = 1'b1;
    run(40);
    chk("rst_hold", {21'd0, joy1, joy2, changed}, 32'd0);
    run(20);
    chk("all_pressed", {22'd0, joy1, joy2}, {22'd0, 5'b10000, 5'b10000});
    cur_a = 5'h1f; cur_b = 5'h1f;
    run(70);

    // Up press latency and single strobe.
    cur_a = 5'b11110;
    wait_bit("lat_up", 0, 4, 43, 53, nc);
    for (int k = 0; k < 5; k++) begin step(); if (changed) nc++; end
    chk("chg_once", nc, 1);

    // Fire bounce: 30 pressed, 5 released, then held.
    cur_a = 5'b01110; run(30);
    chk("bounce_no_fire", {31'd0, joy1[0]}, 32'd0);
    cur_a = 5'b11110; run(5);
    cur_a = 5'b01110;
    wait_bit("lat_fire_bounce", 0, 0, 43, 53, nc);
    cur_a = 5'h1f; run(70);

    // Opposing left/right on port B, then release right.
    cur_b = 5'b10011; run(70);
    chk("lr_both", {30'd0, joy2[1], joy2[2]}, 32'd0);
    cur_b = 5'b10111; run(70);
    chk("lr_left", {30'd0, joy2[1], joy2[2]}, 32'd2);
    cur_b = 5'h1f; run(70);

    // Reset 30 cycles into a debounce discards progress.
    cur_a = 5'b11101; run(30);
    cur_rn = 1'b0; run(1);
    chk("mid_rst", {22'd0, joy1, joy2}, 32'd0);
    cur_rn = 1'b1;
    wait_bit("lat_after_rst", 0, 3, 43, 53, nc);
    cur_a = 5'h1f; run(70);

    // Autofire with fire held.
    cur_a = 5'b01111; run(70);
    cur_af = 1'b1;
`ifdef JOY_PORT_CONDITIONER_AUTOFIRE_EN
    begin
      logic prev;
      int   len;
      do_chk = 1'b0;
      prev = joy1[0];
      len = 0;
      for (int k = 0; k < 700; k++) begin
        step();
        if (joy1[0] == prev) len++;
        else begin runs.push_back(len); len = 1; prev = joy1[0]; end
      end
      chk("af_runs", {31'd0, runs.size() >= 4}, 32'd1);
      for (int r = 1; r < runs.size(); r++) chk("af_half", runs[r], 100);
      do_chk = 1'b1;
    end
`else
    for (int k = 0; k < 400; k++) begin
      step();
      chk("af_off_fire", {31'd0, joy1[0]}, 32'd1);
    end
`endif
    cur_af = 1'b0;
    cur_a = 5'h1f;
`ifdef JOY_PORT_CONDITIONER_AUTOFIRE_EN
    do_chk = 1'b0; run(70); do_chk = 1'b1;
`else
    run(70);
`endif

    // Random holds: short bounces mixed with long presses, rare resets.
    for (int ev = 0; ev < 120; ev++) begin
      int hold;
      int ln;
      hold = ($urandom_range(0, 9) < 6) ? $urandom_range(1, 8) : $urandom_range(40, 90);
      ln = $urandom_range(0, 9);
      if (ln < 5) cur_a[ln] = ~cur_a[ln];
      else        cur_b[ln-5] = ~cur_b[ln-5];
      if ($urandom_range(0, 39) == 0) begin
        cur_rn = 1'b0; run(1); cur_rn = 1'b1;
      end
      run(hold);
    end
    run(70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
